// File: rtl/glut_stage_driver.sv
// glut_stage_driver: host-side feeder and collector for one basic_block_x4 stage.
// Operand pairs are buffered while idle, streamed into the block's east/north
// ports under a stage_start window, and the west results are buffered for the
// host on an AXI-stream-style master port.
module glut_stage_driver #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 128,
  parameter int DRAIN_MAX = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_start,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic                     cfg_block_en,
  input  logic [2:0]               cfg_input_sel_a,
  input  logic [2:0]               cfg_input_sel_b,
  input  logic [2:0]               cfg_output_sel,
  output logic                     ready_for_cmd,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  input  logic                     s_tvalid,
  input  logic [DATA_W-1:0]        s_a_tdata,
  input  logic [DATA_W-1:0]        s_b_tdata,
  output logic                     s_tready,
  output logic                     stage_start,
  output logic                     block_en,
  output logic [2:0]               input_sel_a,
  output logic [2:0]               input_sel_b,
  output logic [2:0]               output_sel,
  output logic                     east_tvalid,
  output logic [DATA_W-1:0]        east_tdata,
  output logic                     north_tvalid,
  output logic [DATA_W-1:0]        north_tdata,
  input  logic                     west_tvalid,
  input  logic [DATA_W-1:0]        west_tdata,
  output logic                     m_tvalid,
  output logic [DATA_W-1:0]        m_tdata,
  input  logic                     m_tready
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int DCW = $clog2(DRAIN_MAX + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q;
  logic [LW-1:0]     len_q, iss_cnt_q, rcv_cnt_q, rcv_cnt_d;
  logic [DCW-1:0]    drain_cnt_q;
  logic              stage_start_q, block_en_q, done_q, timeout_q;
  logic [2:0]        sel_a_q, sel_b_q, sel_o_q;
  logic              east_v_q;
  logic [DATA_W-1:0] east_d_q, north_d_q;

  // Operand buffer (pairs) and result buffer storage/pointers.
  logic [DATA_W-1:0] op_a_mem [DEPTH];
  logic [DATA_W-1:0] op_b_mem [DEPTH];
  logic [DATA_W-1:0] res_mem  [DEPTH];
  logic [AW-1:0]     op_wr_q, op_rd_q, res_wr_q, res_rd_q;
  logic [LW-1:0]     occ_q, res_cnt_q;

  logic              cmd_acc_s, op_push_s, op_pop_s, res_push_s, res_pop_s;
  logic [LW-1:0]     len_sel_s;

  assign busy          = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign ready_for_cmd = (state_q == S_IDLE) && (res_cnt_q == LW'(0));
  assign s_tready      = (state_q == S_IDLE) && (occ_q != LW'(DEPTH));
  assign m_tvalid      = (res_cnt_q != LW'(0));
  assign m_tdata       = res_mem[res_rd_q];

  assign stage_start   = stage_start_q;
  assign block_en      = block_en_q;
  assign input_sel_a   = sel_a_q;
  assign input_sel_b   = sel_b_q;
  assign output_sel    = sel_o_q;
  assign east_tvalid   = east_v_q;
  assign north_tvalid  = east_v_q;
  assign east_tdata    = east_d_q;
  assign north_tdata   = north_d_q;
  assign done          = done_q;
  assign timeout_err   = timeout_q;

  // Handshake decode: command acceptance, run length clamp, buffer push/pop.
  always_comb begin
    cmd_acc_s  = cmd_start && ready_for_cmd;
    if (cfg_len < occ_q) begin
      len_sel_s = cfg_len;
    end else begin
      len_sel_s = occ_q;
    end
    op_push_s  = s_tvalid && s_tready;
    op_pop_s   = (cmd_acc_s && (len_sel_s != LW'(0))) ||
                 ((state_q == S_STREAM) && (iss_cnt_q < len_q));
    // Results past the requested length are dropped, which also bounds the
    // result buffer at len_q entries.
    res_push_s = busy && west_tvalid && (rcv_cnt_q < len_q);
    res_pop_s  = m_tvalid && m_tready;
    rcv_cnt_d  = rcv_cnt_q + LW'(res_push_s);
  end

  // Buffer storage writes (data only, pointers carry the valid state).
  always_ff @(posedge clk) begin
    if (op_push_s) begin
      op_a_mem[op_wr_q] <= s_a_tdata;
      op_b_mem[op_wr_q] <= s_b_tdata;
    end
    if (res_push_s) begin
      res_mem[res_wr_q] <= west_tdata;
    end
  end

  // Buffer pointers and occupancy counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_wr_q   <= AW'(0);
      op_rd_q   <= AW'(0);
      occ_q     <= LW'(0);
      res_wr_q  <= AW'(0);
      res_rd_q  <= AW'(0);
      res_cnt_q <= LW'(0);
    end else begin
      if (op_push_s)  op_wr_q  <= op_wr_q + AW'(1);
      else            op_wr_q  <= op_wr_q;
      if (op_pop_s)   op_rd_q  <= op_rd_q + AW'(1);
      else            op_rd_q  <= op_rd_q;
      if (res_push_s) res_wr_q <= res_wr_q + AW'(1);
      else            res_wr_q <= res_wr_q;
      if (res_pop_s)  res_rd_q <= res_rd_q + AW'(1);
      else            res_rd_q <= res_rd_q;
      occ_q     <= occ_q + LW'(op_push_s) - LW'(op_pop_s);
      res_cnt_q <= res_cnt_q + LW'(res_push_s) - LW'(res_pop_s);
    end
  end

  // Run control FSM with registered stage-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= LW'(0);
      iss_cnt_q     <= LW'(0);
      rcv_cnt_q     <= LW'(0);
      drain_cnt_q   <= DCW'(0);
      stage_start_q <= 1'b0;
      block_en_q    <= 1'b0;
      sel_a_q       <= 3'd0;
      sel_b_q       <= 3'd0;
      sel_o_q       <= 3'd0;
      east_v_q      <= 1'b0;
      east_d_q      <= {DATA_W{1'b0}};
      north_d_q     <= {DATA_W{1'b0}};
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_acc_s) begin
            block_en_q  <= cfg_block_en;
            sel_a_q     <= cfg_input_sel_a;
            sel_b_q     <= cfg_input_sel_b;
            sel_o_q     <= cfg_output_sel;
            len_q       <= len_sel_s;
            timeout_q   <= 1'b0;
            rcv_cnt_q   <= LW'(0);
            drain_cnt_q <= DCW'(0);
            if (len_sel_s == LW'(0)) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              iss_cnt_q <= LW'(0);
            end else begin
              // First beat is presented in the cycle after acceptance.
              state_q       <= S_STREAM;
              stage_start_q <= 1'b1;
              east_v_q      <= 1'b1;
              east_d_q      <= op_a_mem[op_rd_q];
              north_d_q     <= op_b_mem[op_rd_q];
              iss_cnt_q     <= LW'(1);
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_STREAM: begin
          rcv_cnt_q <= rcv_cnt_d;
          if (iss_cnt_q < len_q) begin
            east_d_q  <= op_a_mem[op_rd_q];
            north_d_q <= op_b_mem[op_rd_q];
            iss_cnt_q <= iss_cnt_q + LW'(1);
          end else begin
            state_q   <= S_DRAIN;
            east_v_q  <= 1'b0;
            east_d_q  <= {DATA_W{1'b0}};
            north_d_q <= {DATA_W{1'b0}};
          end
        end
        S_DRAIN: begin
          // Count this cycle's capture so the window closes on the last result.
          rcv_cnt_q <= rcv_cnt_d;
          if (rcv_cnt_d == len_q) begin
            state_q       <= S_DONE;
            stage_start_q <= 1'b0;
            done_q        <= 1'b1;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            state_q       <= S_DONE;
            stage_start_q <= 1'b0;
            done_q        <= 1'b1;
            timeout_q     <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DCW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q       <= S_IDLE;
          stage_start_q <= 1'b0;
          east_v_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/glut_stage_driver.md
Name: glut_stage_driver

Overview:
- Upstream source and downstream sink for one basic_block_x4 stage in the glut array.
- Buffers operand-A/operand-B beat pairs from the host and latches the stage configuration on a start command.
- Streams the pairs into the block's east (A) and north (B) ports under a stage_start window, collects the west_out results into a result buffer, and hands them back over an AXI-stream-style master port.

Parameters:
DEPTH, 16, entries in the operand buffer and in the result buffer (power of 2, >=2)
DATA_W, 128, beat width (4 x fp32 lanes)
DRAIN_MAX, 64, maximum DRAIN cycles allowed before a timeout is declared

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
cmd_start  in  1  start pulse; accepted only when ready_for_cmd=1
cfg_len  in  $clog2(DEPTH)+1  number of beats to issue
cfg_block_en  in  1  block_en value for the run
cfg_input_sel_a  in  3  input_sel_a value for the run
cfg_input_sel_b  in  3  input_sel_b value for the run
cfg_output_sel  in  3  output_sel value for the run
ready_for_cmd  out  1  state==IDLE and result buffer empty
busy  out  1  state is STREAM or DRAIN
done  out  1  one-cycle pulse at run end
timeout_err  out  1  sticky; cleared at next accepted cmd_start
s_tvalid  in  1  operand pair valid
s_a_tdata  in  DATA_W  operand A
s_b_tdata  in  DATA_W  operand B
s_tready  out  1  state==IDLE and operand buffer not full
stage_start  out  1  stage window to block
block_en  out  1  latched cfg_block_en
input_sel_a  out  3  latched cfg_input_sel_a
input_sel_b  out  3  latched cfg_input_sel_b
output_sel  out  3  latched cfg_output_sel
east_tvalid  out  1  operand A valid to block
east_tdata  out  DATA_W  operand A to block
north_tvalid  out  1  operand B valid to block
north_tdata  out  DATA_W  operand B to block
west_tvalid  in  1  result valid from block
west_tdata  in  DATA_W  result data from block
m_tvalid  out  1  result buffer not empty
m_tdata  out  DATA_W  head of result buffer (FWFT)
m_tready  in  1  host consumes the head entry

Behaviour:
- Reset (rst=1 at a clock edge):
  - state to IDLE; both buffers emptied; all counters cleared.
  - Every registered output goes to 0: stage_start, block_en, all sel outputs, east/north tvalid and tdata, done, timeout_err.
  - Reset asserted mid-run aborts the run with no done pulse; all buffered operands and results are discarded.
- Operand buffer: FIFO of {A,B} pairs. Pushes on s_tvalid&s_tready; writes happen only in IDLE. Occupancy occ ranges 0..DEPTH.
- cmd_start is ignored unless ready_for_cmd=1. On acceptance:
  - latch cfg_* into the block_en/sel outputs; these hold until the next accepted command.
  - set len_r = min(cfg_len, occ) and clear timeout_err.
  - if len_r==0: go to DONE directly, with no stage_start.
  - otherwise go to STREAM.
- STREAM, len_r cycles:
  - stage_start=1, east_tvalid=north_tvalid=1.
  - east/north tdata driven from the FIFO head; one pop per cycle.
  - The first beat appears in the cycle after cmd_start acceptance.
- DRAIN:
  - stage_start=1; east/north tvalid=0 and tdata=0.
  - Exit to DONE when rcv_cnt==len_r.
  - Also exit to DONE after DRAIN_MAX cycles in DRAIN, setting timeout_err=1.
- DONE, 1 cycle: stage_start=0, done=1; next state IDLE.
- Result capture: every cycle with busy=1 and west_tvalid=1 pushes west_tdata and increments rcv_cnt.
  - Captures beyond len_r are dropped and not counted.
  - west_tvalid is ignored outside busy.
  - The result buffer cannot overflow because len_r<=DEPTH and the buffer is empty at start.
- Result readout: m_tvalid=!empty; pop on m_tvalid&m_tready. Popping during a run is allowed; a simultaneous push and pop leaves the count unchanged.
- Beats remaining in the operand buffer after a run (occ>len_r) stay for the next command.
- Expected round trip through the block:
  - bypass (block_en=0): 2 cycles from east beat to west_tvalid.
  - compute: operator latency + 2.
  - stage_start stays high until the results drain or the timeout fires.

Test Plan:
- Bypass run: load 4 pairs with A=i*0x11 and B=0, cfg_block_en=0, cfg_len=4, start -> stage_start high for 4+2 cycles (STREAM 4, DRAIN 2); m side returns A0..A3 in order; done pulses once; timeout_err=0.
- Clamp: load 3 pairs, cfg_len=8 -> exactly 3 east beats, done after 3 results, no timeout.
- Timeout: cfg_len=2, bench holds west_tvalid=0 -> DRAIN lasts 64 cycles, then done=1 and timeout_err=1; the next accepted cmd_start clears timeout_err.
- Back-pressure: m_tready=0 throughout a 16-beat run -> result buffer full at 16, ready_for_cmd=0, cmd_start ignored; pop 16 beats -> ready_for_cmd=1.
- Zero length: cfg_len=0 -> done the cycle after start, stage_start never asserted, operand buffer unchanged.
- Reset mid-STREAM at beat 2 of 5 -> next cycle all outputs are 0, occ=0, m_tvalid=0, no done pulse.
